instruction_issuer: RTL and testbench

//  Producer end of the 88-bit control-unit instruction word. Host pushes 32-bit words,

---
 rtl/instruction_issuer_if.sv | 36 +++
 rtl/instruction_issuer.sv | 184 ++++++++++++++++++
 tb/tb_instruction_issuer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_issuer_if.sv
// Host-side and decoder-side signal bundle for instruction_issuer.
//
// Handshake: a host word on host_wr_data is transferred on a rising clock edge
// where host_wr_valid and host_wr_ready are both high. The host holds valid and
// data steady until that edge. Ready never depends on valid, so the host may
// wait for ready before raising valid, or raise valid first.
interface instruction_issuer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          host_wr_valid;
  logic          host_wr_ready;
  logic [31:0]   host_wr_data;
  logic          clear;
  logic          start;
  logic          stall;
  logic [87:0]   instruction;
  logic          instr_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] fifo_count;
  logic          dbg_state;   // 0 = IDLE, 1 = ISSUE

  // Host / bench side
  modport master (
    output host_wr_valid, host_wr_data, clear, start, stall,
    input  host_wr_ready, instruction, instr_valid, busy, done, fifo_count, dbg_state
  );

  // Issuer side
  modport slave (
    input  host_wr_valid, host_wr_data, clear, start, stall,
    output host_wr_ready, instruction, instr_valid, busy, done, fifo_count, dbg_state
  );
endinterface

// File: rtl/instruction_issuer.sv
// Assembles three 32-bit host words into an 88-bit instruction plus 8-bit hold
// count, queues them, and replays them to the control-unit decoder one per cycle.
// Each entry is issued for hold+1 valid cycles; bits in PULSE_MASK are driven
// only on the first of those cycles.
module instruction_issuer #(
  parameter int          DEPTH      = 16,
  parameter logic [87:0] PULSE_MASK = 88'h3
) (
  input logic           clk,
  input logic           rst,
  instruction_issuer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  // Word assembly
  logic [1:0]    word_cnt_q;
  logic [31:0]   w0_q;
  logic [31:0]   w1_q;

  // FIFO: entry = {hold[7:0], instr[87:0]}
  logic [95:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Issue engine
  state_t        state_q;
  logic [87:0]   cur_instr_q;   // entry currently being issued
  logic [8:0]    rem_q;         // valid cycles still owed by the current entry
  logic          first_q;       // next emitted cycle carries the pulse bits
  logic [87:0]   instruction_q;
  logic          instr_valid_q;
  logic          done_q;

  logic          full;
  logic          empty;
  logic          ready;
  logic          accept;
  logic          push;
  logic          pop;
  logic [95:0]   head;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  // Only the third word needs a free slot; ignores a pop on the same edge.
  assign ready  = !((word_cnt_q == 2'd2) && full);
  assign accept = bus.host_wr_valid && ready && !bus.clear;
  assign push   = accept && (word_cnt_q == 2'd2);
  assign head   = mem_q[rd_ptr_q];

  // Head is consumed on start from IDLE, or once the current entry has used up
  // all its valid cycles and issue is not stalled.
  assign pop = !bus.clear && !empty &&
               (((state_q == IDLE) && bus.start) ||
                ((state_q == ISSUE) && !bus.stall && (rem_q == 9'd0)));

  // Collect w0/w1 into staging registers; w2 completes the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q <= 2'd0;
      w0_q       <= '0;
      w1_q       <= '0;
    end else if (bus.clear) begin
      word_cnt_q <= 2'd0;
    end else if (accept) begin
      case (word_cnt_q)
        2'd0: begin
          w0_q       <= bus.host_wr_data;
          word_cnt_q <= 2'd1;
        end
        2'd1: begin
          w1_q       <= bus.host_wr_data;
          word_cnt_q <= 2'd2;
        end
        default: word_cnt_q <= 2'd0;
      endcase
    end
  end

  // FIFO storage; contents need no reset because count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.host_wr_data, w1_q, w0_q};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Issue FSM with registered decoder-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_instr_q   <= '0;
      rem_q         <= '0;
      first_q       <= 1'b0;
      instruction_q <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else if (bus.clear) begin
      state_q       <= IDLE;
      cur_instr_q   <= '0;
      rem_q         <= '0;
      first_q       <= 1'b0;
      instruction_q <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          instruction_q <= '0;
          instr_valid_q <= 1'b0;
          if (bus.start) begin
            if (pop) begin
              state_q     <= ISSUE;
              cur_instr_q <= head[87:0];
              if (bus.stall) begin
                // Entry loaded but not yet emitted: all hold+1 cycles owed.
                rem_q   <= {1'b0, head[95:88]} + 9'd1;
                first_q <= 1'b1;
              end else begin
                instruction_q <= head[87:0];
                instr_valid_q <= 1'b1;
                rem_q         <= {1'b0, head[95:88]};
                first_q       <= 1'b0;
              end
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.stall) begin
            instruction_q <= '0;
            instr_valid_q <= 1'b0;
          end else if (rem_q != 9'd0) begin
            instruction_q <= first_q ? cur_instr_q : (cur_instr_q & ~PULSE_MASK);
            instr_valid_q <= 1'b1;
            rem_q         <= rem_q - 9'd1;
            first_q       <= 1'b0;
          end else if (pop) begin
            cur_instr_q   <= head[87:0];
            instruction_q <= head[87:0];
            instr_valid_q <= 1'b1;
            rem_q         <= {1'b0, head[95:88]};
            first_q       <= 1'b0;
          end else begin
            instruction_q <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.host_wr_ready = ready;
  assign bus.instruction   = instruction_q;
  assign bus.instr_valid   = instr_valid_q;
  assign bus.busy          = (state_q == ISSUE);
  assign bus.done          = done_q;
  assign bus.fifo_count    = count_q;
  assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_instruction_issuer.sv
// Bench for instruction_issuer: table of single-entry vectors plus hand-written
// multi-cycle sequences; a monitor compares every valid issue cycle against an
// expected-instruction queue filled when entries are pushed.
module tb_instruction_issuer;
  logic clk;
  logic rst;

  instruction_issuer_if #(.DEPTH(16)) bus ();

  instruction_issuer #(.DEPTH(16), .PULSE_MASK(88'h3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  logic mon_en = 1'b0;
  logic [87:0] exp_q[$];

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [87:0] e_first;
    logic [87:0] e_rest;
    int          e_len;
  } vec_t;

  vec_t vecs[4];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_entry(input logic [87:0] f, input logic [87:0] r, input int len);
    exp_q.push_back(f);
    for (int k = 1; k < len; k++) exp_q.push_back(r);
  endtask

  // Driver tasks
  task automatic push_word(input logic [31:0] d);
    int t;
    t = 0;
    bus.host_wr_valid = 1'b1;
    bus.host_wr_data  = d;
    while (!bus.host_wr_ready && t < 200) begin
      step();
      t++;
    end
    if (!bus.host_wr_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout: ready stuck low for word %h", d);
    end
    step();
    bus.host_wr_valid = 1'b0;
  endtask

  task automatic push_entry(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    push_word(w0);
    push_word(w1);
    push_word(w2);
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      if (bus.done) begin
        cyc = i;
        break;
      end
      step();
    end
  endtask

  // Scoreboard monitor: every cycle, valid issues must match the queue head
  // and non-valid cycles must present a NOP.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      if (bus.instr_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got %h expected no issue", bus.instruction);
        end else begin
          chk("sb_issue", bus.instruction, exp_q.pop_front());
        end
      end else begin
        chk("nop_zero", bus.instruction, 88'h0);
      end
    end
  end

  initial begin
    int cyc;
    int v0;

    vecs[0] = '{32'h0000_0083, 32'h0, 32'h0200_0000, 88'h83, 88'h80, 3};
    vecs[1] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h00AB_CDEF,
                88'hABCDEF_12345678_FFFFFFFF, 88'h0, 1};
    vecs[2] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h0180_0000,
                88'h800000_DEADBEEF_00000001, 88'h800000_DEADBEEF_00000000, 2};
    vecs[3] = '{32'h0000_0007, 32'h0, 32'h0355_0000,
                88'h550000_00000000_00000007, 88'h550000_00000000_00000004, 4};

    rst               = 1'b1;
    bus.host_wr_valid = 1'b0;
    bus.host_wr_data  = '0;
    bus.clear         = 1'b0;
    bus.start         = 1'b0;
    bus.stall         = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // Reset state
    chk("rst_instr", bus.instruction, 88'h0);
    chk("rst_valid", 88'(bus.instr_valid), 88'h0);
    chk("rst_busy", 88'(bus.busy), 88'h0);
    chk("rst_done", 88'(bus.done), 88'h0);
    chk("rst_count", 88'(bus.fifo_count), 88'h0);
    chk("rst_ready", 88'(bus.host_wr_ready), 88'h1);

    // A dangling partial word is discarded by clear
    push_word(32'hAAAA_AAAA);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;

    // Table: one entry at a time, check issue sequence and done timing
    for (int i = 0; i < 4; i++) begin
      push_entry(vecs[i].w0, vecs[i].w1, vecs[i].w2);
      exp_entry(vecs[i].e_first, vecs[i].e_rest, vecs[i].e_len);
      chk("tbl_count", 88'(bus.fifo_count), 88'h1);
      start_pulse();
      chk("tbl_busy_run", 88'(bus.busy), 88'h1);
      wait_done(300, cyc);
      chk("tbl_done_cycle", 88'(cyc), 88'(vecs[i].e_len + 1));
      chk("tbl_done_busy", 88'(bus.busy), 88'h0);
      chk("tbl_done_instr", bus.instruction, 88'h0);
      step();
      chk("tbl_done_pulse", 88'(bus.done), 88'h0);
    end

    // Three hold=0 entries back to back, no bubble
    v0 = n_valid;
    for (int i = 1; i <= 3; i++) begin
      push_entry(32'(i), 32'h0, 32'h0);
      exp_entry(88'(i), 88'h0, 1);
    end
    start_pulse();
    wait_done(50, cyc);
    chk("b2b_done_cycle", 88'(cyc), 88'd4);
    chk("b2b_valid_cnt", 88'(n_valid - v0), 88'd3);

    // Fill to DEPTH, then ready drops only on the third word of the 17th entry
    v0 = n_valid;
    for (int i = 0; i < 16; i++) begin
      push_entry(32'(i + 16), 32'h0, 32'h0);
      exp_entry(88'(i + 16), 88'h0, 1);
    end
    chk("full_count", 88'(bus.fifo_count), 88'd16);
    chk("full_ready_w0", 88'(bus.host_wr_ready), 88'h1);
    push_word(32'h99);
    push_word(32'h0);
    bus.host_wr_valid = 1'b1;
    bus.host_wr_data  = 32'h0;
    exp_entry(88'h99, 88'h0, 1);
    chk("full_ready_w2", 88'(bus.host_wr_ready), 88'h0);
    step();
    chk("full_ready_hold", 88'(bus.host_wr_ready), 88'h0);
    chk("full_count_hold", 88'(bus.fifo_count), 88'd16);
    start_pulse();
    chk("full_after_pop_cnt", 88'(bus.fifo_count), 88'd15);
    chk("full_after_pop_rdy", 88'(bus.host_wr_ready), 88'h1);
    step();
    bus.host_wr_valid = 1'b0;
    chk("push_pop_same_edge", 88'(bus.fifo_count), 88'd15);
    wait_done(100, cyc);
    chk("full_done_seen", 88'(cyc > 0), 88'h1);
    chk("full_valid_cnt", 88'(n_valid - v0), 88'd17);

    // Stall mid-hold and stall before the next entry's first cycle
    v0 = n_valid;
    push_entry(32'h83, 32'h0, 32'h0300_0000);
    exp_entry(88'h83, 88'h80, 4);
    push_entry(32'h83, 32'h0, 32'h0100_0000);
    exp_entry(88'h83, 88'h80, 2);
    start_pulse();
    step();
    bus.stall = 1'b1;
    step();
    chk("stall_nop_valid", 88'(bus.instr_valid), 88'h0);
    chk("stall_busy", 88'(bus.busy), 88'h1);
    step();
    bus.stall = 1'b0;
    step();
    step();
    bus.stall = 1'b1;
    step();
    chk("stall_pre_first_valid", 88'(bus.instr_valid), 88'h0);
    chk("stall_pre_first_cnt", 88'(bus.fifo_count), 88'd1);
    bus.stall = 1'b0;
    step();
    chk("stall_first_word", bus.instruction, 88'h83);
    wait_done(50, cyc);
    chk("stall_done_cycle", 88'(cyc), 88'd3);
    chk("stall_valid_cnt", 88'(n_valid - v0), 88'd6);

    // Start with empty FIFO
    v0 = n_valid;
    start_pulse();
    chk("empty_done", 88'(bus.done), 88'h1);
    chk("empty_busy", 88'(bus.busy), 88'h0);
    step();
    chk("empty_done_pulse", 88'(bus.done), 88'h0);
    chk("empty_no_valid", 88'(n_valid - v0), 88'h0);

    // Clear during ISSUE
    push_entry(32'h5, 32'h0, 32'h0A00_0000);
    exp_entry(88'h5, 88'h4, 11);
    push_entry(32'h6, 32'h0, 32'h0);
    exp_entry(88'h6, 88'h0, 1);
    start_pulse();
    step();
    step();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    exp_q.delete();
    chk("clr_busy", 88'(bus.busy), 88'h0);
    chk("clr_count", 88'(bus.fifo_count), 88'h0);
    chk("clr_valid", 88'(bus.instr_valid), 88'h0);
    chk("clr_instr", bus.instruction, 88'h0);
    chk("clr_ready", 88'(bus.host_wr_ready), 88'h1);
    for (int i = 0; i < 4; i++) begin
      chk("clr_no_done", 88'(bus.done), 88'h0);
      step();
    end

    // Asynchronous reset mid-run
    push_entry(32'h11, 32'h0, 32'h0500_0000);
    exp_entry(88'h11, 88'h10, 6);
    push_entry(32'h12, 32'h0, 32'h0);
    exp_entry(88'h12, 88'h0, 1);
    start_pulse();
    step();
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_instr", bus.instruction, 88'h0);
    chk("arst_valid", 88'(bus.instr_valid), 88'h0);
    chk("arst_busy", 88'(bus.busy), 88'h0);
    chk("arst_count", 88'(bus.fifo_count), 88'h0);
    chk("arst_ready", 88'(bus.host_wr_ready), 88'h1);
    step();
    rst = 1'b0;
    step();
    chk("arst_idle", 88'(bus.dbg_state), 88'h0);

    chk("sb_drained", 88'(exp_q.size()), 88'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
